// File: rtl/count_wrap_monitor.sv
// Observer for a 4-bit up/down counter. It emits carry and borrow pulses on wrap,
// keeps a modular count of net wraps, and flags stalls and illegal steps.
module count_wrap_monitor #(
    parameter int WRAP_W       = 8,
    parameter int STALL_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              up_down,
    input  logic [3:0]        count,
    output logic              carry_out,
    output logic              borrow_out,
    output logic [WRAP_W-1:0] wrap_count,
    output logic              stall,
    output logic              step_err
);

    localparam int SC_W = $clog2(STALL_CYCLES + 1);
    localparam logic [SC_W-1:0] SC_MAX = SC_W'(STALL_CYCLES);

    typedef enum logic {PRIME, TRACK} state_t;

    state_t            state_q;
    logic [3:0]        prev_count_q;
    logic              prev_dir_q;
    logic [SC_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [WRAP_W-1:0] wrap_q, wrap_d;
    logic              carry_q, borrow_q, stall_q, err_q;

    logic [3:0] delta;
    logic       is_hold, is_up, is_dn, is_carry, is_borrow, bad_step;

    assign delta     = count - prev_count_q;
    assign is_hold   = (delta == 4'd0);
    assign is_up     = (delta == 4'd1);
    assign is_dn     = (delta == 4'hF);
    // A wrap is decided by the value pair alone, so a direction mismatch still counts it.
    assign is_carry  = is_up && (prev_count_q == 4'hF);
    assign is_borrow = is_dn && (prev_count_q == 4'h0);
    assign bad_step  = !is_hold && ((is_up && !prev_dir_q) ||
                                    (is_dn &&  prev_dir_q) ||
                                    (!is_up && !is_dn));

    always_comb begin
        stall_cnt_d = (stall_cnt_q == SC_MAX) ? SC_MAX : stall_cnt_q + 1'b1;
        wrap_d      = wrap_q;
        if (is_carry)
            wrap_d = wrap_q + 1'b1;
        else if (is_borrow)
            wrap_d = wrap_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= PRIME;
            prev_count_q <= 4'd0;
            prev_dir_q   <= 1'b0;
            stall_cnt_q  <= '0;
            wrap_q       <= '0;
            carry_q      <= 1'b0;
            borrow_q     <= 1'b0;
            stall_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            prev_count_q <= count;
            prev_dir_q   <= up_down;
            carry_q      <= 1'b0;
            borrow_q     <= 1'b0;
            case (state_q)
                PRIME: state_q <= TRACK;
                TRACK: begin
                    carry_q  <= is_carry;
                    borrow_q <= is_borrow;
                    wrap_q   <= wrap_d;
                    if (bad_step)
                        err_q <= 1'b1;
                    if (is_hold) begin
                        stall_cnt_q <= stall_cnt_d;
                        stall_q     <= (stall_cnt_d == SC_MAX);
                    end else begin
                        stall_cnt_q <= '0;
                        stall_q     <= 1'b0;
                    end
                end
                default: state_q <= PRIME;
            endcase
        end
    end

    assign carry_out  = carry_q;
    assign borrow_out = borrow_q;
    assign wrap_count = wrap_q;
    assign stall      = stall_q;
    assign step_err   = err_q;

endmodule

// File: tb/tb_count_wrap_monitor.sv
// Scoreboard bench: stimulus pushes hand-derived expectations and a monitor pops them
// and compares them one clock edge later.
module tb_count_wrap_monitor;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       up_down = 1'b1;
    logic [3:0] count = 4'd0;
    logic       carry_out, borrow_out, stall, step_err;
    logic [7:0] wrap_count;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string      tag;
        logic       c;
        logic       b;
        logic [7:0] w;
        logic       s;
        logic       e;
    } exp_t;

    exp_t sb[$];

    count_wrap_monitor #(.WRAP_W(8), .STALL_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .up_down(up_down), .count(count),
        .carry_out(carry_out), .borrow_out(borrow_out), .wrap_count(wrap_count),
        .stall(stall), .step_err(step_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input string fld, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s.%s actual=%0d required=%0d", tag, fld, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk(e.tag, "carry",  {7'd0, carry_out},  {7'd0, e.c});
                chk(e.tag, "borrow", {7'd0, borrow_out}, {7'd0, e.b});
                chk(e.tag, "wrap",   wrap_count,          e.w);
                chk(e.tag, "stall",  {7'd0, stall},       {7'd0, e.s});
                chk(e.tag, "err",    {7'd0, step_err},    {7'd0, e.e});
            end
        end
    end

    task automatic drv(input logic r, input logic ud, input logic [3:0] cnt,
                       input logic ec, input logic eb, input logic [7:0] ew,
                       input logic es, input logic ee, input string tag);
        exp_t e;
        @(negedge clk);
        reset   = r;
        up_down = ud;
        count   = cnt;
        e.tag = tag; e.c = ec; e.b = eb; e.w = ew; e.s = es; e.e = ee;
        sb.push_back(e);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [3:0] c;
        logic [7:0] w;
        logic       cy;

        // 1: wrap up
        drv(1, 1, 4'd0, 0, 0, 8'd0, 0, 0, "reset");
        drv(0, 1, 4'd0, 0, 0, 8'd0, 0, 0, "prime0");
        for (int i = 1; i < 16; i++)
            drv(0, 1, 4'(i), 0, 0, 8'd0, 0, 0, "up_run");
        drv(0, 1, 4'd0, 1, 0, 8'd1, 0, 0, "carry");
        drv(0, 0, 4'd1, 0, 0, 8'd1, 0, 0, "carry_drop");

        // 2: wrap down twice, 1 -> 0 -> 255
        drv(0, 0, 4'd0,  0, 0, 8'd1, 0, 0, "down_to0");
        drv(0, 0, 4'd15, 0, 1, 8'd0, 0, 0, "borrow1");
        for (int i = 14; i >= 0; i--)
            drv(0, 0, 4'(i), 0, 0, 8'd0, 0, 0, "down_run");
        drv(0, 0, 4'd15, 0, 1, 8'd255, 0, 0, "borrow2");

        // 3: stall at 5, released by a legal step to 6
        for (int i = 14; i >= 6; i--)
            drv(0, 0, 4'(i), 0, 0, 8'd255, 0, 0, "down_run2");
        drv(0, 1, 4'd5, 0, 0, 8'd255, 0, 0, "to5");
        for (int k = 1; k <= 4; k++)
            drv(0, 1, 4'd5, 0, 0, 8'd255, (k == 4), 0, "stall_hold");
        drv(0, 0, 4'd6, 0, 0, 8'd255, 0, 0, "stall_clear");

        // 4: illegal jump 3 -> 6, sticky error, wraps still counted
        drv(0, 0, 4'd5, 0, 0, 8'd255, 0, 0, "dn5");
        drv(0, 0, 4'd4, 0, 0, 8'd255, 0, 0, "dn4");
        drv(0, 1, 4'd3, 0, 0, 8'd255, 0, 0, "dn3");
        drv(0, 1, 4'd6, 0, 0, 8'd255, 0, 1, "jump");
        c = 4'd6;
        w = 8'd255;
        for (int i = 0; i < 58; i++) begin
            c  = c + 4'd1;
            cy = (c == 4'd0);
            if (cy) w = w + 8'd1;
            drv(0, 1, c, cy, 0, w, 0, 1, "err_sticky_run");
        end
        for (int k = 1; k <= 4; k++)
            drv(0, 1, 4'd0, 0, 0, 8'd3, (k == 4), 1, "stall_hold2");

        // 6: mid-run reset with wrap=3, err=1, stall=1
        drv(1, 1, 4'd0,  0, 0, 8'd0, 0, 0, "rst_mid");
        drv(0, 1, 4'd12, 0, 0, 8'd0, 0, 0, "prime12");
        drv(0, 1, 4'd13, 0, 0, 8'd0, 0, 0, "step13");

        // 5: direction mismatch 9 -> 8 while prev_dir=1
        drv(1, 1, 4'd0, 0, 0, 8'd0, 0, 0, "rst2");
        drv(0, 1, 4'd9, 0, 0, 8'd0, 0, 0, "prime9");
        drv(0, 1, 4'd8, 0, 0, 8'd0, 0, 1, "dir_mismatch");

        // mismatched wrap: 15 -> 0 with prev_dir=0 still carries
        drv(1, 0, 4'd0,  0, 0, 8'd0, 0, 0, "rst3");
        drv(0, 0, 4'd15, 0, 0, 8'd0, 0, 0, "prime15");
        drv(0, 0, 4'd0,  1, 0, 8'd1, 0, 1, "wrap_mismatch");
        drv(0, 0, 4'd15, 0, 1, 8'd0, 0, 1, "borrow_with_err");
        drv(0, 0, 4'd14, 0, 0, 8'd0, 0, 1, "after_borrow");

        for (int k = 0; k < 10 && sb.size() != 0; k++)
            @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain actual=%0d pending required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/count_wrap_monitor.md
Name: count_wrap_monitor

Overview:
Downstream observer for the 4-bit synchronous up/down counter. Samples the counter's `count` and `up_down` every clock and emits one-cycle carry/borrow pulses on wrap-around. Maintains a modular wrap counter, so counter + monitor form a wider cascaded count. Flags stalls and illegal steps for self-checking in benches and in system use.

Parameters:
WRAP_W, 8, width of the wrap_count accumulator (modulo 2^WRAP_W)
STALL_CYCLES, 4, consecutive unchanged samples (>=1) before stall asserts; stall counter width = $clog2(STALL_CYCLES+1)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high; shared with the counter
up_down  input  1  direction control driven to the counter (1 = up, 0 = down)
count  input  4  counter output being monitored
carry_out  output  1  one-cycle pulse on 15->0 step while counting up
borrow_out  output  1  one-cycle pulse on 0->15 step while counting down
wrap_count  output  WRAP_W  net wraps: +1 per carry, -1 per borrow, modular
stall  output  1  count unchanged for >= STALL_CYCLES consecutive samples
step_err  output  1  sticky: illegal step or direction mismatch seen

Behaviour:
- Single clock domain. Reset is synchronous, active-high, and has priority over all other logic.
- Reset values: carry_out=0, borrow_out=0, wrap_count=0, stall=0, step_err=0. Internal prev_count=0, prev_dir=0, stall_cnt=0, state=PRIME.
- FSM states: PRIME, TRACK.
  - PRIME: entered on reset. First edge with reset=0 captures count->prev_count and up_down->prev_dir, performs no checks, and goes to TRACK.
  - TRACK: remains in TRACK until reset.
- Direction is checked against prev_dir: the up_down the counter used to produce the current count.
- TRACK, per edge, with delta = (count - prev_count) mod 16:
  - delta=0:
    - stall_cnt increments, saturating at STALL_CYCLES.
    - stall=1 once stall_cnt reaches STALL_CYCLES.
  - delta=1:
    - Legal if prev_dir=1, else step_err<=1.
    - If prev_count=15 and count=0: carry_out<=1 and wrap_count<=wrap_count+1.
  - delta=15 (minus 1):
    - Legal if prev_dir=0, else step_err<=1.
    - If prev_count=0 and count=15: borrow_out<=1 and wrap_count<=wrap_count-1.
  - Any other delta: step_err<=1; no pulse; wrap_count unchanged.
  - Any delta≠0: stall_cnt<=0 and stall<=0 on the same edge.
  - Every edge: prev_count<=count and prev_dir<=up_down.
- Timing:
  - All outputs are registered; no combinational path from inputs to outputs.
  - Pulses are high for exactly the one cycle following the edge that sampled the wrap.
- carry_out and borrow_out are never high together and are 0 in PRIME.
- wrap_count is modular: from 2^WRAP_W-1, +1 gives 0; from 0, -1 gives 2^WRAP_W-1. No saturation and no error on wrap.
- Wraps are counted even when step_err is set. step_err only clears on reset.
- Mid-operation reset clears everything and returns to PRIME. The first post-reset sample is never an error, regardless of count value.
- Direction mismatch on a wrap step (e.g. 15->0 with prev_dir=0): step_err<=1, but the carry pulse and increment still occur, since wrap is determined by the value pair.

Test Plan:
1. Wrap up: reset 1 cycle, up_down=1, counter runs 0..15->0. Required: carry_out high exactly 1 cycle after the edge sampling 0, wrap_count=1, step_err=0, stall=0.
2. Wrap down: continue from wrap_count=1, up_down=0, through 0->15 twice. Required: borrow_out pulses twice; wrap_count goes 1->0->255 (WRAP_W=8); step_err=0.
3. Stall: hold count at 5 with STALL_CYCLES=4. Required: stall=1 after the 4th identical sample, not earlier. Then step to 6 with prev_dir=1. Required: stall=0 next cycle, step_err=0.
4. Illegal jump: drive count 3->6. Required: step_err=1 next cycle. It stays 1 through later legal steps and a subsequent wrap, during which carry_out still pulses and wrap_count increments.
5. Direction mismatch: prev_dir=1, count 9->8. Required: step_err=1, no pulse, wrap_count unchanged.
6. Reset mid-run: with wrap_count=3, step_err=1, stall=1, assert reset 1 cycle, then drive count=12. Required:
   - All outputs 0 after the reset edge.
   - The sample of 12 primes with no error.
   - The next legal step 12->13 (up) keeps step_err=0.
